// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised register file.
// Contents:
//   clr_state_t - clear engine states (ST_IDLE, ST_CLEAR)
//   LCD_BYTE_W  - bits exported per entry on the LCD tap
//   ZERO_ADDR   - index of the hardwired zero register
package regfile_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_t;

  localparam int LCD_BYTE_W = 8;
  localparam int ZERO_ADDR  = 0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file.
// Ports:
//   mem     - full array contents (entry i at mem[i])
//   addr    - read address
//   byp_en  - a qualified write is in flight this cycle (bypass enabled)
//   wr_addr - address of that write
//   wr_data - data of that write
//   data    - read result; 0 for the zero register
// The bypass compare is always present; the top ties byp_en low when
// REGFILE_BYPASS_EN is not defined, so it folds away.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] mem,
  input  logic [ADDR_WIDTH-1:0]                      addr,
  input  logic                                       byp_en,
  input  logic [ADDR_WIDTH-1:0]                      wr_addr,
  input  logic [DATA_WIDTH-1:0]                      wr_data,
  output logic [DATA_WIDTH-1:0]                      data
);

  always_comb begin
    data = mem[addr];
    if (addr == ADDR_WIDTH'(ZERO_ADDR))
      data = '0;
    else if (byp_en && (addr == wr_addr))
      data = wr_data;
  end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file with zero register, hardware-loaded slot,
// sequential clear engine and debug/LCD taps.
// Ports:
//   CLK, RESET       - clock; synchronous active-high reset
//   WRITE/INADDRESS/IN - write port (ignored while BUSY or to entry 0)
//   OUTADDRESS/OUT   - NUM_READ packed read ports, port k at [k*W +: W]
//   HW_DATA/HW_VALID - zero-extended load into entry HW_REG_INDEX
//   CLEAR_REQ/BUSY   - start / status of the one-entry-per-cycle clear
//   DEBUG_ADDR/DEBUG_DATA - stored-value debug read (never bypassed)
//   DEBUG_DATA_LCD   - low byte of entries LCD_REGS-1..0, entry 0 in LSB
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle write
// onto matching read ports.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int NUM_READ     = 2,
  parameter int HW_REG_INDEX = 31,
  parameter int HW_WIDTH     = 13,
  parameter int LCD_REGS     = 6
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           WRITE,
  input  logic [ADDR_WIDTH-1:0]          INADDRESS,
  input  logic [DATA_WIDTH-1:0]          IN,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] OUTADDRESS,
  output logic [NUM_READ*DATA_WIDTH-1:0] OUT,
  input  logic [HW_WIDTH-1:0]            HW_DATA,
  input  logic                           HW_VALID,
  input  logic                           CLEAR_REQ,
  output logic                           BUSY,
  input  logic [ADDR_WIDTH-1:0]          DEBUG_ADDR,
  output logic [DATA_WIDTH-1:0]          DEBUG_DATA,
  output logic [LCD_BYTE_W*LCD_REGS-1:0] DEBUG_DATA_LCD
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  clr_state_t                       state, state_nx;
  logic [ADDR_WIDTH-1:0]            ptr, ptr_nx;
  logic                             busy, wr_ok, byp_en;
  logic [DATA_WIDTH-1:0]            hw_ext;

  assign busy   = (state == ST_CLEAR);
  assign BUSY   = busy;
  assign wr_ok  = WRITE && !busy && (INADDRESS != ADDR_WIDTH'(ZERO_ADDR));
  assign hw_ext = DATA_WIDTH'(HW_DATA);

`ifdef REGFILE_BYPASS_EN
  assign byp_en = wr_ok;
`else
  assign byp_en = 1'b0;
`endif

  // Clear FSM: walk the pointer over every entry, leave after the last.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      ST_IDLE: begin
        if (CLEAR_REQ) begin
          state_nx = ST_CLEAR;
          ptr_nx   = '0;
        end
      end
      ST_CLEAR: begin
        ptr_nx = ptr + 1'b1;  // wraps to 0 on the final entry
        if (ptr == ADDR_WIDTH'(DEPTH-1))
          state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        ptr_nx   = '0;
      end
    endcase
  end

  // Entry 0 is never written after reset, so it stays zero in storage too.
  // Per-entry priority: clear > software write > hardware load.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem   <= '0;
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      for (int i = 1; i < DEPTH; i++) begin
        if (busy && (ptr == ADDR_WIDTH'(i)))
          mem[i] <= '0;
        else if (wr_ok && (INADDRESS == ADDR_WIDTH'(i)))
          mem[i] <= IN;
        else if (HW_VALID && (i == HW_REG_INDEX))
          mem[i] <= hw_ext;
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_READ; k++) begin : g_rp
      regfile_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
      ) u_rp (
        .mem    (mem),
        .addr   (OUTADDRESS[k*ADDR_WIDTH +: ADDR_WIDTH]),
        .byp_en (byp_en),
        .wr_addr(INADDRESS),
        .wr_data(IN),
        .data   (OUT[k*DATA_WIDTH +: DATA_WIDTH])
      );
    end
    for (k = 0; k < LCD_REGS; k++) begin : g_lcd
      assign DEBUG_DATA_LCD[k*LCD_BYTE_W +: LCD_BYTE_W] = mem[k][LCD_BYTE_W-1:0];
    end
  endgenerate

  assign DEBUG_DATA = (DEBUG_ADDR == ADDR_WIDTH'(ZERO_ADDR)) ? '0 : mem[DEBUG_ADDR];

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed scenarios plus random
// traffic compared against an array model that applies the register-file
// rules edge by edge. Clear progress is tracked by edge count from the
// request edge, not by a pointer register.
module tb_regfile_param;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NR  = 2;
  localparam int D   = 32;
  localparam int HWI = 31;
  localparam int HWW = 13;
  localparam int LR  = 6;

  logic             CLK = 1'b0;
  logic             RESET, WRITE, HW_VALID, CLEAR_REQ;
  logic [AW-1:0]    INADDRESS, DEBUG_ADDR;
  logic [DW-1:0]    IN, DEBUG_DATA;
  logic [NR*AW-1:0] OUTADDRESS;
  logic [NR*DW-1:0] OUT;
  logic [HWW-1:0]   HW_DATA;
  logic             BUSY;
  logic [8*LR-1:0]  DEBUG_DATA_LCD;

  regfile_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR),
                  .HW_REG_INDEX(HWI), .HW_WIDTH(HWW), .LCD_REGS(LR)) dut (
    .CLK(CLK), .RESET(RESET), .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .OUTADDRESS(OUTADDRESS), .OUT(OUT), .HW_DATA(HW_DATA), .HW_VALID(HW_VALID),
    .CLEAR_REQ(CLEAR_REQ), .BUSY(BUSY), .DEBUG_ADDR(DEBUG_ADDR),
    .DEBUG_DATA(DEBUG_DATA), .DEBUG_DATA_LCD(DEBUG_DATA_LCD)
  );

  always #5 CLK = ~CLK;

  int chks = 0;
  int errs = 0;

  logic [DW-1:0] model [D];
  int  ecnt    = 0;
  bit  clr_act = 0;
  int  clr_n   = 0;

  function automatic bit exp_busy();
    return clr_act && (ecnt >= clr_n) && (ecnt < clr_n + D);
  endfunction

  // Expected read port value given current inputs.
  function automatic logic [DW-1:0] exp_out(int a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (WRITE && !exp_busy() && INADDRESS != 0 && int'(INADDRESS) == a) return IN;
`endif
    return model[a];
  endfunction

  // Apply the rules for the coming edge to the model, then cross the edge.
  task automatic step();
    int p;
    ecnt++;
    if (RESET) begin
      for (int i = 0; i < D; i++) model[i] = '0;
      clr_act = 0;
    end else if (clr_act && ecnt > clr_n && ecnt <= clr_n + D) begin
      p = ecnt - clr_n - 1;
      if (HW_VALID) model[HWI] = {{(DW-HWW){1'b0}}, HW_DATA};
      if (p != 0) model[p] = '0;
      if (ecnt == clr_n + D) clr_act = 0;
    end else begin
      if (CLEAR_REQ) begin clr_act = 1; clr_n = ecnt; end
      if (HW_VALID) model[HWI] = {{(DW-HWW){1'b0}}, HW_DATA};
      if (WRITE && INADDRESS != 0) model[INADDRESS] = IN;
    end
    @(posedge CLK); #1;
  endtask

  task automatic idle_inputs();
    WRITE = 0; HW_VALID = 0; CLEAR_REQ = 0; INADDRESS = '0; IN = '0; HW_DATA = '0;
  endtask

  task automatic test_reset();
    RESET = 1; idle_inputs(); OUTADDRESS = {5'd5, 5'd3}; DEBUG_ADDR = 5'd2;
    step(); step();
    RESET = 0; #1;
    chks++; if (BUSY !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    chks++; if (OUT !== '0) begin errs++; $display("FAIL reset_out got %h exp 0", OUT); end
    chks++; if (DEBUG_DATA !== '0) begin errs++; $display("FAIL reset_dbg got %h exp 0", DEBUG_DATA); end
    chks++; if (DEBUG_DATA_LCD !== '0) begin errs++; $display("FAIL reset_lcd got %h exp 0", DEBUG_DATA_LCD); end
  endtask

  task automatic test_write_read();
    WRITE = 1; INADDRESS = 5'd5; IN = 32'hDEADBEEF; step(); idle_inputs();
    OUTADDRESS = {5'd0, 5'd5}; DEBUG_ADDR = 5'd5; #1;
    chks++; if (OUT[31:0] !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_out0 got %h exp deadbeef", OUT[31:0]); end
    chks++; if (DEBUG_DATA !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_dbg got %h exp deadbeef", DEBUG_DATA); end
    chks++; if (DEBUG_DATA_LCD[47:40] !== 8'hEF) begin errs++; $display("FAIL wr_lcd5 got %h exp ef", DEBUG_DATA_LCD[47:40]); end
  endtask

  task automatic test_zero_reg();
    WRITE = 1; INADDRESS = 5'd0; IN = 32'h1234; step(); idle_inputs();
    OUTADDRESS = '0; DEBUG_ADDR = '0; #1;
    chks++; if (OUT !== '0) begin errs++; $display("FAIL zero_out got %h exp 0", OUT); end
    chks++; if (DEBUG_DATA !== '0) begin errs++; $display("FAIL zero_dbg got %h exp 0", DEBUG_DATA); end
    chks++; if (DEBUG_DATA_LCD[7:0] !== 8'h00) begin errs++; $display("FAIL zero_lcd got %h exp 0", DEBUG_DATA_LCD[7:0]); end
  endtask

  task automatic test_hw_reg();
    HW_VALID = 1; HW_DATA = 13'h1ABC; WRITE = 1; INADDRESS = 5'd31; IN = 32'h55;
    step(); idle_inputs(); OUTADDRESS = {5'd31, 5'd31}; #1;
    chks++; if (OUT[63:32] !== 32'h55) begin errs++; $display("FAIL hw_swwins got %h exp 55", OUT[63:32]); end
    HW_VALID = 1; HW_DATA = 13'h1ABC; step(); idle_inputs(); #1;
    chks++; if (OUT[31:0] !== 32'h00001ABC) begin errs++; $display("FAIL hw_load got %h exp 00001abc", OUT[31:0]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      WRITE = 1'($urandom); INADDRESS = AW'($urandom); IN = $urandom;
      HW_VALID = ($urandom_range(0, 3) == 0); HW_DATA = HWW'($urandom);
      OUTADDRESS = (c % 4 == 0) ? {INADDRESS, INADDRESS} : (NR*AW)'($urandom);
      DEBUG_ADDR = AW'($urandom); #1;
      for (int k = 0; k < NR; k++) begin
        chks++;
        if (OUT[k*DW +: DW] !== exp_out(int'(OUTADDRESS[k*AW +: AW]))) begin
          errs++; $display("FAIL rand_out%0d cyc %0d addr %0d got %h exp %h", k, c,
                           OUTADDRESS[k*AW +: AW], OUT[k*DW +: DW], exp_out(int'(OUTADDRESS[k*AW +: AW])));
        end
      end
      chks++;
      if (DEBUG_DATA !== model[DEBUG_ADDR]) begin
        errs++; $display("FAIL rand_dbg cyc %0d got %h exp %h", c, DEBUG_DATA, model[DEBUG_ADDR]);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic fill_all();
    for (int i = 1; i < D; i++) begin
      WRITE = 1; INADDRESS = AW'(i); IN = $urandom | 32'h1; step();
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int busy_cnt, guard;
    fill_all();
    CLEAR_REQ = 1; step(); CLEAR_REQ = 0;
    busy_cnt = 0; guard = 0;
    while (BUSY === 1'b1 && guard < 100) begin
      guard++;
      chks++; if (BUSY !== exp_busy()) begin errs++; $display("FAIL clr_busy cyc %0d got %b exp %b", busy_cnt, BUSY, exp_busy()); end
      WRITE = 1; INADDRESS = AW'($urandom_range(1, D-1)); IN = $urandom;
      HW_VALID = 1'($urandom); HW_DATA = HWW'($urandom);
      CLEAR_REQ = (busy_cnt == 5); OUTADDRESS = (NR*AW)'($urandom); #1;
      for (int k = 0; k < NR; k++) begin
        chks++;
        if (OUT[k*DW +: DW] !== exp_out(int'(OUTADDRESS[k*AW +: AW]))) begin
          errs++; $display("FAIL clr_out%0d cyc %0d got %h exp %h", k, busy_cnt,
                           OUT[k*DW +: DW], exp_out(int'(OUTADDRESS[k*AW +: AW])));
        end
      end
      busy_cnt++;
      step();
    end
    idle_inputs(); #1;
    if (guard >= 100) begin errs++; $display("FAIL clr_timeout got %0d exp busy to drop", guard); end
    chks++; if (busy_cnt !== D) begin errs++; $display("FAIL clr_len got %0d exp %0d", busy_cnt, D); end
    chks++; if (BUSY !== 1'b0) begin errs++; $display("FAIL clr_done got %b exp 0", BUSY); end
    for (int i = 0; i < D; i++) begin
      DEBUG_ADDR = AW'(i); #1;
      chks++; if (DEBUG_DATA !== '0 || model[i] !== '0) begin
        errs++; $display("FAIL clr_entry%0d got %h exp 0", i, DEBUG_DATA);
      end
    end
    step();
    chks++; if (BUSY !== 1'b0) begin errs++; $display("FAIL clr_rereq got %b exp 0", BUSY); end
  endtask

  task automatic test_reset_mid_clear();
    fill_all();
    CLEAR_REQ = 1; step(); CLEAR_REQ = 0;
    repeat (10) step();
    RESET = 1; step(); RESET = 0; #1;
    chks++; if (BUSY !== 1'b0) begin errs++; $display("FAIL rstmid_busy got %b exp 0", BUSY); end
    for (int i = 0; i < D; i++) begin
      DEBUG_ADDR = AW'(i); #1;
      chks++; if (DEBUG_DATA !== '0) begin errs++; $display("FAIL rstmid_entry%0d got %h exp 0", i, DEBUG_DATA); end
    end
    step();
    chks++; if (BUSY !== 1'b0) begin errs++; $display("FAIL rstmid_stay got %b exp 0", BUSY); end
    WRITE = 1; INADDRESS = 5'd7; IN = 32'h99; step(); idle_inputs();
    DEBUG_ADDR = 5'd7; #1;
    chks++; if (DEBUG_DATA !== 32'h99) begin errs++; $display("FAIL rstmid_wr got %h exp 99", DEBUG_DATA); end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
    WRITE = 1; INADDRESS = 5'd3; IN = 32'h11; step();
    WRITE = 1; INADDRESS = 5'd3; IN = 32'h77; OUTADDRESS = {5'd3, 5'd0}; DEBUG_ADDR = 5'd3; #1;
`ifdef REGFILE_BYPASS_EN
    want = 32'h77;
`else
    want = 32'h11;
`endif
    chks++; if (OUT[63:32] !== want) begin errs++; $display("FAIL byp_same got %h exp %h", OUT[63:32], want); end
    chks++; if (DEBUG_DATA !== 32'h11) begin errs++; $display("FAIL byp_dbg got %h exp 11", DEBUG_DATA); end
    step(); idle_inputs(); #1;
    chks++; if (OUT[63:32] !== 32'h77) begin errs++; $display("FAIL byp_next got %h exp 77", OUT[63:32]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_hw_reg();
    test_random();
    test_clear();
    test_reset_mid_clear();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", chks, errs);
    $finish;
  end

endmodule
